// File: rtl/pong_pkg.sv
// Shared definitions for the pong score display.
// Holds the seven-segment codes, the segment bit positions, the score and
// frame-counter widths, and the PLAY/GAME_OVER state encoding.
package pong_pkg;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned FRAME_W = 5;
    localparam int unsigned SEG_W   = 7;

    // Segment bit positions within a 7-bit mask
    localparam int unsigned SEG_BIT_TOP   = 0;
    localparam int unsigned SEG_BIT_UL    = 1;
    localparam int unsigned SEG_BIT_UR    = 2;
    localparam int unsigned SEG_BIT_MID   = 3;
    localparam int unsigned SEG_BIT_LL    = 4;
    localparam int unsigned SEG_BIT_LR    = 5;
    localparam int unsigned SEG_BIT_BOT   = 6;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5D;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h2E;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6B;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h25;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic [0:0] {
        StPlay     = 1'b0,
        StGameOver = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_encode.sv
// Combinational 4-bit value to seven-segment mask encoder.
// Ports:
//   i_value : 4-bit value to display (10..15 render blank)
//   o_seg   : 7-bit segment mask (bit0 top ... bit6 bottom)
module seg7_encode
    import pong_pkg::*;
(
    input  logic [SCORE_W-1:0] i_value,
    output logic [SEG_W-1:0]   o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_value)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_segment_encoder.sv
// Pong score keeper and seven-segment digit driver.
// Counts rising edges on the point inputs, ends the game when a player
// reaches WIN_SCORE, and refreshes the two digit registers once per video
// frame. While the game is over the winner's digit blinks with a 32-frame
// period (16 frames on, 16 blank).
// Ports:
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_point_left/right : point inputs, one point per rising edge
//   i_frame_start      : one-cycle pulse per frame, triggers digit refresh
//   i_restart          : clear scores and start a new game
//   o_digit_left/right : registered segment masks
//   o_game_over        : high while a player has won
//   o_winner           : 0 = left, 1 = right (valid with o_game_over)
module score_segment_encoder
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE = 9
)
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_point_left,
    input  logic             i_point_right,
    input  logic             i_frame_start,
    input  logic             i_restart,
    output logic [SEG_W-1:0] o_digit_left,
    output logic [SEG_W-1:0] o_digit_right,
    output logic             o_game_over,
    output logic             o_winner
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    state_e             r_state, w_state_next;
    logic [SCORE_W-1:0] r_score_left, r_score_right;
    logic [SCORE_W-1:0] w_score_left_next, w_score_right_next;
    logic               r_prev_left, r_prev_right;
    logic               w_left_edge, w_right_edge;
    logic               r_winner, w_winner_next;
    logic [FRAME_W-1:0] r_frame_cnt, w_frame_cnt_next, w_frame_cnt_inc;
    logic [SEG_W-1:0]   w_seg_left, w_seg_right;
    logic [SEG_W-1:0]   r_digit_left, r_digit_right;
    logic [SEG_W-1:0]   w_digit_left_next, w_digit_right_next;
    logic               w_blank_left, w_blank_right;

    assign w_left_edge     = i_point_left & ~r_prev_left;
    assign w_right_edge    = i_point_right & ~r_prev_right;
    assign w_frame_cnt_inc = r_frame_cnt + 1'b1;

    seg7_encode u_seg_left (
        .i_value (r_score_left),
        .o_seg   (w_seg_left)
    );

    seg7_encode u_seg_right (
        .i_value (r_score_right),
        .o_seg   (w_seg_right)
    );

    // Next-state: scores, FSM, winner and frame counter
    always_comb begin
        w_state_next       = r_state;
        w_score_left_next  = r_score_left;
        w_score_right_next = r_score_right;
        w_winner_next      = r_winner;
        w_frame_cnt_next   = i_frame_start ? w_frame_cnt_inc : r_frame_cnt;

        if (i_restart) begin
            // Restart wins over any same-cycle point, which is dropped
            w_state_next       = StPlay;
            w_score_left_next  = '0;
            w_score_right_next = '0;
            w_winner_next      = 1'b0;
            w_frame_cnt_next   = '0;
        end else begin
            case (r_state)
                StPlay: begin
                    if (w_left_edge && (r_score_left < WIN)) begin
                        w_score_left_next = r_score_left + 1'b1;
                    end
                    if (w_right_edge && (r_score_right < WIN)) begin
                        w_score_right_next = r_score_right + 1'b1;
                    end
                    // Left is checked first so a simultaneous win goes to left
                    if (w_score_left_next == WIN) begin
                        w_state_next     = StGameOver;
                        w_winner_next    = 1'b0;
                        w_frame_cnt_next = '0;
                    end else if (w_score_right_next == WIN) begin
                        w_state_next     = StGameOver;
                        w_winner_next    = 1'b1;
                        w_frame_cnt_next = '0;
                    end
                end
                StGameOver: begin
                    // Points ignored, scores held until restart
                end
                default: w_state_next = StPlay;
            endcase
        end
    end

    // Digit refresh. Blink phase uses the post-increment frame count so that
    // frames 1-15 after game over show the digit and frames 16-31 blank it.
    always_comb begin
        w_blank_left  = (r_state == StGameOver) && !r_winner && w_frame_cnt_inc[FRAME_W-1];
        w_blank_right = (r_state == StGameOver) && r_winner && w_frame_cnt_inc[FRAME_W-1];

        w_digit_left_next  = r_digit_left;
        w_digit_right_next = r_digit_right;
        if (i_frame_start) begin
            w_digit_left_next  = w_blank_left ? SEG_BLANK : w_seg_left;
            w_digit_right_next = w_blank_right ? SEG_BLANK : w_seg_right;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StPlay;
            r_score_left  <= '0;
            r_score_right <= '0;
            // History set high so an input held through reset is not a point
            r_prev_left   <= 1'b1;
            r_prev_right  <= 1'b1;
            r_winner      <= 1'b0;
            r_frame_cnt   <= '0;
            r_digit_left  <= SEG_0;
            r_digit_right <= SEG_0;
        end else begin
            r_state       <= w_state_next;
            r_score_left  <= w_score_left_next;
            r_score_right <= w_score_right_next;
            r_prev_left   <= i_point_left;
            r_prev_right  <= i_point_right;
            r_winner      <= w_winner_next;
            r_frame_cnt   <= w_frame_cnt_next;
            r_digit_left  <= w_digit_left_next;
            r_digit_right <= w_digit_right_next;
        end
    end

    assign o_digit_left  = r_digit_left;
    assign o_digit_right = r_digit_right;
    assign o_game_over   = (r_state == StGameOver);
    assign o_winner      = r_winner;

endmodule

// File: tb/tb_score_segment_encoder.sv
// Directed self-checking bench for score_segment_encoder (WIN_SCORE = 9).
module tb_score_segment_encoder;

    logic       clk;
    logic       rst;
    logic       pl;
    logic       pr;
    logic       fs;
    logic       rs;
    logic [6:0] dl;
    logic [6:0] dr;
    logic       go;
    logic       win;

    int checks = 0;
    int errors = 0;

    score_segment_encoder #(.WIN_SCORE(9)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_point_left  (pl),
        .i_point_right (pr),
        .i_frame_start (fs),
        .i_restart     (rs),
        .o_digit_left  (dl),
        .o_digit_right (dr),
        .o_game_over   (go),
        .o_winner      (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic l, input logic r);
        pl = l;
        pr = r;
        tick();
        pl = 1'b0;
        pr = 1'b0;
        tick();
    endtask

    task automatic frame();
        fs = 1'b1;
        tick();
        fs = 1'b0;
    endtask

    task automatic restart();
        rs = 1'b1;
        tick();
        rs = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        // Left held high through reset release must not count
        rst = 1'b1;
        pl  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        pl = 1'b0;
        tick();
        checks++;
        if (dl !== 7'h77 || dr !== 7'h77) begin
            errors++;
            $display("FAIL reset_digits: got %h/%h expected 77/77", dl, dr);
        end
        checks++;
        if (go !== 1'b0 || win !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got go=%b win=%b expected 0/0", go, win);
        end
        frame();
        checks++;
        if (dl !== 7'h77 || dr !== 7'h77) begin
            errors++;
            $display("FAIL reset_frame: got %h/%h expected 77/77", dl, dr);
        end
    endtask

    task automatic test_frame_hold();
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        tick();
        checks++;
        if (dl !== 7'h77 || dr !== 7'h77) begin
            errors++;
            $display("FAIL hold_no_frame: got %h/%h expected 77/77", dl, dr);
        end
        fs = 1'b1;
        #1;
        checks++;
        if (dl !== 7'h77) begin
            errors++;
            $display("FAIL hold_same_cycle: got %h expected 77", dl);
        end
        tick();
        fs = 1'b0;
        checks++;
        if (dl !== 7'h6D || dr !== 7'h77) begin
            errors++;
            $display("FAIL hold_after_frame: got %h/%h expected 6d/77", dl, dr);
        end
    endtask

    task automatic test_simultaneous();
        restart();
        pulse(1'b1, 1'b1);
        frame();
        checks++;
        if (dl !== 7'h24 || dr !== 7'h24) begin
            errors++;
            $display("FAIL simultaneous: got %h/%h expected 24/24", dl, dr);
        end
        pr = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        pr = 1'b0;
        tick();
        frame();
        checks++;
        if (dl !== 7'h24 || dr !== 7'h5D) begin
            errors++;
            $display("FAIL held_high: got %h/%h expected 24/5d", dl, dr);
        end
    endtask

    task automatic test_left_win();
        restart();
        for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0);
        checks++;
        if (go !== 1'b0) begin
            errors++;
            $display("FAIL at_eight: got go=%b expected 0", go);
        end
        pl = 1'b1;
        tick();
        checks++;
        if (go !== 1'b1 || win !== 1'b0) begin
            errors++;
            $display("FAIL left_win: got go=%b win=%b expected 1/0", go, win);
        end
        pl = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1);
        // Frames 1..32 after game over: blank only on frames 16..31
        for (int f = 1; f <= 32; f++) begin
            frame();
            checks++;
            if (f >= 16 && f <= 31) begin
                if (dl !== 7'h00) begin
                    errors++;
                    $display("FAIL blink_frame%0d: got %h expected 00", f, dl);
                end
            end else if (dl !== 7'h6F) begin
                errors++;
                $display("FAIL blink_frame%0d: got %h expected 6f", f, dl);
            end
            checks++;
            if (dr !== 7'h77) begin
                errors++;
                $display("FAIL loser_frame%0d: got %h expected 77", f, dr);
            end
        end
    endtask

    task automatic test_restart();
        // Still in GAME_OVER from the left win
        rs = 1'b1;
        pl = 1'b1;
        tick();
        checks++;
        if (go !== 1'b0) begin
            errors++;
            $display("FAIL restart_go: got %b expected 0", go);
        end
        rs = 1'b0;
        pl = 1'b0;
        tick();
        frame();
        checks++;
        if (dl !== 7'h77 || dr !== 7'h77) begin
            errors++;
            $display("FAIL restart_digits: got %h/%h expected 77/77", dl, dr);
        end
    endtask

    task automatic test_right_win_and_tie();
        restart();
        for (int i = 0; i < 8; i++) pulse(1'b0, 1'b1);
        pr = 1'b1;
        tick();
        checks++;
        if (go !== 1'b1 || win !== 1'b1) begin
            errors++;
            $display("FAIL right_win: got go=%b win=%b expected 1/1", go, win);
        end
        pr = 1'b0;
        tick();
        for (int f = 1; f <= 16; f++) frame();
        checks++;
        if (dr !== 7'h00 || dl !== 7'h77) begin
            errors++;
            $display("FAIL right_blink: got %h/%h expected 77/00 (l/r)", dl, dr);
        end
        restart();
        for (int i = 0; i < 8; i++) pulse(1'b1, 1'b1);
        pl = 1'b1;
        pr = 1'b1;
        tick();
        checks++;
        if (go !== 1'b1 || win !== 1'b0) begin
            errors++;
            $display("FAIL tie_win: got go=%b win=%b expected 1/0", go, win);
        end
        pl = 1'b0;
        pr = 1'b0;
        tick();
    endtask

    task automatic test_reset_midgame();
        restart();
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1);
        frame();
        checks++;
        if (dl !== 7'h6B || dr !== 7'h6D) begin
            errors++;
            $display("FAIL score_5_3: got %h/%h expected 6b/6d", dl, dr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dl !== 7'h77 || dr !== 7'h77 || go !== 1'b0) begin
            errors++;
            $display("FAIL midgame_reset: got %h/%h go=%b expected 77/77 0", dl, dr, go);
        end
        tick();
        frame();
        checks++;
        if (dl !== 7'h77 || dr !== 7'h77) begin
            errors++;
            $display("FAIL midgame_scores: got %h/%h expected 77/77", dl, dr);
        end
    endtask

    initial begin
        rst = 1'b1;
        pl  = 1'b0;
        pr  = 1'b0;
        fs  = 1'b0;
        rs  = 1'b0;
        test_reset();
        test_frame_hold();
        test_simultaneous();
        test_left_win();
        test_restart();
        test_right_win_and_tie();
        test_reset_midgame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
